// File: rtl/uart_pixel_rx.sv
// ---------------------------------------------------------------------------
// uart_pixel_rx
//   8N1 UART receiver (LSB first) that hands each received byte to a pixel
//   writer through a valid/busy handshake. RX is resynchronised before use.
//   Mid-bit sampling is derived from a free cycle counter that restarts on
//   every state change. A low stop bit discards the byte and parks the
//   receiver in BREAK until the line returns high.
//
// Ports
//   CLK          system clock, all state on rising edge
//   RST          asynchronous, active-high reset
//   RX           raw UART line, idle high
//   i_busy       downstream writer busy; a byte is consumed when low
//   o_data       received byte, stable while o_valid is high
//   o_valid      o_data holds an unconsumed byte
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte completed while previous unconsumed
// ---------------------------------------------------------------------------
module uart_pixel_rx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic       i_busy,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun
);

    // Wide enough to hold CLKS_PER_BIT-1 without wrapping.
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             rx_meta, rx_s;
    logic             done;
    logic             ferr;
    logic             consume;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never fabricates a falling edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a two-stage shift; a
            // blocking '=' here would collapse both flops into one.
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned (no latch inferred).
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        done      = 1'b0;
        ferr      = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                    bit_nxt   = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high level was a glitch.
                if (cnt == HALF_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must go high before a new start is accepted.
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign consume = o_valid & ~i_busy;

    // Output holding register. A completing byte loads only when the slot is
    // empty or being consumed this same cycle; otherwise it is dropped and
    // flagged as an overrun.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= ferr;
            o_overrun   <= done & o_valid & i_busy;
            if (done) begin
                o_valid <= 1'b1;
                if (!o_valid || consume) begin
                    o_data <= shreg;
                end
            end else if (consume) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_pixel_rx
//   Self-checking bench for uart_pixel_rx. Two instances: one with a 4-cycle
//   bit period for most scenarios, one with the default 104-cycle period.
//   Expected bytes and arrival cycles come from the UART frame rules: a byte
//   becomes valid a fixed number of cycles after its start bit goes on the
//   line (synchronizer, start detection, half a bit, nine full bits, one
//   register stage).
// ---------------------------------------------------------------------------
module tb_uart_pixel_rx;

    localparam int N  = 4;
    localparam int NB = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx4, rx104;
    logic       busy, busy104;
    logic [7:0] d4, d104;
    logic       v4, v104, fe4, fe104, ov4, ov104;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_pixel_rx #(.CLKS_PER_BIT(N)) dut (
        .CLK(clk), .RST(rst), .RX(rx4), .i_busy(busy),
        .o_data(d4), .o_valid(v4), .o_frame_err(fe4), .o_overrun(ov4)
    );

    uart_pixel_rx #(.CLKS_PER_BIT(NB)) dut104 (
        .CLK(clk), .RST(rst), .RX(rx104), .i_busy(busy104),
        .o_data(d104), .o_valid(v104), .o_frame_err(fe104), .o_overrun(ov104)
    );

    // ---------------- monitors (sample on falling edge) ----------------
    logic [7:0] got_d[$];
    int         got_c[$];
    int         vcyc, fe_n, fe_last, ov_n, ov_last;
    logic       vq = 1'b0;

    logic [7:0] got104_d[$];
    int         got104_c[$];
    int         fe104_n, ov104_n;
    logic       vq104 = 1'b0;

    always @(negedge clk) begin
        if (v4 && !vq) begin
            got_d.push_back(d4);
            got_c.push_back(cyc);
        end
        vq = v4;
        if (v4)  vcyc++;
        if (fe4) begin fe_n++; fe_last = cyc; end
        if (ov4) begin ov_n++; ov_last = cyc; end

        if (v104 && !vq104) begin
            got104_d.push_back(d104);
            got104_c.push_back(cyc);
        end
        vq104 = v104;
        if (fe104) fe104_n++;
        if (ov104) ov104_n++;
    end

    // ---------------- helpers ----------------
    // Cycles from the start bit appearing on RX to o_valid being seen high:
    // 2 synchronizer + 1 start detect + half bit + 1 entering DATA
    // + 8 data bits + 1 stop bit + 1 output register, minus the final
    // count overlap -> 4 + (n-1)/2 + 9n.
    function automatic int lat(input int n);
        return 4 + (n - 1) / 2 + 9 * n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx104 = v;
        else     rx4   = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b,
                              input logic stop_lvl, output int start);
        int n;
        n = sel ? NB : N;
        start = cyc;
        set_rx(sel, 1'b0);
        tick(n);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            tick(n);
        end
        set_rx(sel, stop_lvl);
        tick(n);
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_c.delete();
        got104_d.delete();
        got104_c.delete();
        vcyc = 0; fe_n = 0; fe_last = -1; ov_n = 0; ov_last = -1;
        fe104_n = 0; ov104_n = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        total++;
        if (d4 !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h exp 00", d4); end
        total++;
        if (v4 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b exp 0", v4); end
        total++;
        if ({fe4, ov4} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %0b exp 00", {fe4, ov4}); end
        total++;
        if ({d104, v104, fe104, ov104} !== 11'd0) begin
            bad++; $display("FAIL reset_dut104: got %0h exp 0", {d104, v104, fe104, ov104});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic();
        int k;
        logic [7:0] g;
        int gc;
        clear_mon();
        send_frame(1'b0, 8'hA5, 1'b1, k);
        tick(10);
        g  = (got_d.size() > 0) ? got_d[0] : 8'hxx;
        gc = (got_c.size() > 0) ? got_c[0] : -1;
        total++;
        if (got_d.size() != 1) begin bad++; $display("FAIL basic_count: got %0d exp 1", got_d.size()); end
        total++;
        if (g !== 8'hA5) begin bad++; $display("FAIL basic_data: got %0h exp a5", g); end
        total++;
        if (gc != k + lat(N)) begin bad++; $display("FAIL basic_latency: got %0d exp %0d", gc, k + lat(N)); end
        total++;
        if (vcyc != 1) begin bad++; $display("FAIL basic_valid_width: got %0d exp 1", vcyc); end
        total++;
        if (fe_n != 0 || ov_n != 0) begin bad++; $display("FAIL basic_flags: got fe=%0d ov=%0d exp 0", fe_n, ov_n); end

        clear_mon();
        send_frame(1'b1, 8'h3C, 1'b1, k);
        tick(20);
        g  = (got104_d.size() > 0) ? got104_d[0] : 8'hxx;
        gc = (got104_c.size() > 0) ? got104_c[0] : -1;
        total++;
        if (got104_d.size() != 1) begin bad++; $display("FAIL b104_count: got %0d exp 1", got104_d.size()); end
        total++;
        if (g !== 8'h3C) begin bad++; $display("FAIL b104_data: got %0h exp 3c", g); end
        total++;
        if (gc != k + lat(NB)) begin bad++; $display("FAIL b104_latency: got %0d exp %0d", gc, k + lat(NB)); end
        total++;
        if (fe104_n != 0 || ov104_n != 0) begin
            bad++; $display("FAIL b104_flags: got fe=%0d ov=%0d exp 0", fe104_n, ov104_n);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_d[$];
        int         exp_c[$];
        logic [7:0] b;
        int         k;
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            tick($urandom_range(0, 3));
            b = 8'($urandom);
            send_frame(1'b0, b, 1'b1, k);
            exp_d.push_back(b);
            exp_c.push_back(k + lat(N));
        end
        tick(10);
        total++;
        if (got_d.size() != exp_d.size()) begin
            bad++; $display("FAIL rand_count: got %0d exp %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
                    bad++;
                    $display("FAIL rand_byte%0d: got %0h@%0d exp %0h@%0d",
                             i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
                end
            end
        end
        total++;
        if (fe_n != 0 || ov_n != 0) begin bad++; $display("FAIL rand_flags: got fe=%0d ov=%0d exp 0", fe_n, ov_n); end
    endtask

    task automatic test_overrun();
        int k1, k2;
        clear_mon();
        busy = 1'b1;
        send_frame(1'b0, 8'h01, 1'b1, k1);
        send_frame(1'b0, 8'h02, 1'b1, k2);
        tick(3);
        total++;
        if (ov_n != 1) begin bad++; $display("FAIL ovr_count: got %0d exp 1", ov_n); end
        total++;
        if (ov_last != k2 + lat(N)) begin bad++; $display("FAIL ovr_time: got %0d exp %0d", ov_last, k2 + lat(N)); end
        total++;
        if (d4 !== 8'h01 || v4 !== 1'b1) begin
            bad++; $display("FAIL ovr_hold: got %0h/%0b exp 01/1", d4, v4);
        end
        busy = 1'b0;
        @(negedge clk);
        total++;
        if (v4 !== 1'b1) begin bad++; $display("FAIL ovr_release_same: got %0b exp 1", v4); end
        @(negedge clk);
        total++;
        if (v4 !== 1'b0) begin bad++; $display("FAIL ovr_release_next: got %0b exp 0", v4); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_same_cycle();
        int k1, k2;
        clear_mon();
        busy = 1'b1;
        send_frame(1'b0, 8'h3A, 1'b1, k1);
        send_frame(1'b0, 8'hC5, 1'b1, k2);
        // Now in the stop-bit sample cycle of the second byte.
        busy = 1'b0;
        @(negedge clk);
        total++;
        if (v4 !== 1'b1 || d4 !== 8'h3A) begin bad++; $display("FAIL same_before: got %0h/%0b exp 3a/1", d4, v4); end
        @(negedge clk);
        total++;
        if (v4 !== 1'b1 || d4 !== 8'hC5) begin bad++; $display("FAIL same_load: got %0h/%0b exp c5/1", d4, v4); end
        total++;
        if (ov_n != 0) begin bad++; $display("FAIL same_no_ovr: got %0d exp 0", ov_n); end
        @(negedge clk);
        total++;
        if (v4 !== 1'b0) begin bad++; $display("FAIL same_consumed: got %0b exp 0", v4); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_err();
        int k, k2;
        logic [7:0] g;
        int gc;
        clear_mon();
        send_frame(1'b0, 8'hFF, 1'b0, k);
        tick(20 * N);
        rx4 = 1'b1;
        tick(3 * N);
        send_frame(1'b0, 8'h55, 1'b1, k2);
        tick(10);
        g  = (got_d.size() > 0) ? got_d[0] : 8'hxx;
        gc = (got_c.size() > 0) ? got_c[0] : -1;
        total++;
        if (fe_n != 1) begin bad++; $display("FAIL ferr_count: got %0d exp 1", fe_n); end
        total++;
        if (fe_last != k + lat(N)) begin bad++; $display("FAIL ferr_time: got %0d exp %0d", fe_last, k + lat(N)); end
        total++;
        if (got_d.size() != 1 || g !== 8'h55) begin
            bad++; $display("FAIL ferr_next_byte: got n=%0d %0h exp n=1 55", got_d.size(), g);
        end
        total++;
        if (gc != k2 + lat(N)) begin bad++; $display("FAIL ferr_next_latency: got %0d exp %0d", gc, k2 + lat(N)); end
    endtask

    task automatic test_glitch();
        int k;
        logic [7:0] g;
        int gc;
        clear_mon();
        rx4 = 1'b0;
        tick(1);
        rx4 = 1'b1;
        tick(6 * N);
        total++;
        if (got_d.size() != 0 || fe_n != 0 || ov_n != 0) begin
            bad++; $display("FAIL glitch_quiet: got n=%0d fe=%0d ov=%0d exp 0", got_d.size(), fe_n, ov_n);
        end
        send_frame(1'b0, 8'h81, 1'b1, k);
        tick(10);
        g  = (got_d.size() > 0) ? got_d[0] : 8'hxx;
        gc = (got_c.size() > 0) ? got_c[0] : -1;
        total++;
        if (g !== 8'h81 || gc != k + lat(N)) begin
            bad++; $display("FAIL glitch_then_byte: got %0h@%0d exp 81@%0d", g, gc, k + lat(N));
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [7:0] c3;
        logic [7:0] g;
        clear_mon();
        c3 = 8'hC3;
        busy = 1'b1;
        send_frame(1'b0, 8'h99, 1'b1, k);
        tick(2);
        total++;
        if (v4 !== 1'b1 || d4 !== 8'h99) begin bad++; $display("FAIL rmid_prefill: got %0h/%0b exp 99/1", d4, v4); end
        rx4 = 1'b0;
        tick(N);
        for (int i = 0; i < 4; i++) begin
            rx4 = c3[i];
            tick(N);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({d4, v4, fe4, ov4} !== 11'd0) begin
            bad++; $display("FAIL rmid_async: got %0h exp 0", {d4, v4, fe4, ov4});
        end
        for (int i = 4; i < 9; i++) begin
            rx4 = (i < 8) ? c3[i] : 1'b1;
            repeat (N) begin
                @(negedge clk);
                total++;
                if ({d4, v4, fe4, ov4} !== 11'd0) begin
                    bad++; $display("FAIL rmid_held: got %0h exp 0", {d4, v4, fe4, ov4});
                end
                @(posedge clk);
                #1;
            end
        end
        rst  = 1'b0;
        busy = 1'b0;
        clear_mon();
        tick(2 * N);
        send_frame(1'b0, 8'h7E, 1'b1, k);
        tick(10);
        g = (got_d.size() > 0) ? got_d[0] : 8'hxx;
        total++;
        if (got_d.size() != 1 || g !== 8'h7E) begin
            bad++; $display("FAIL rmid_only_7e: got n=%0d %0h exp n=1 7e", got_d.size(), g);
        end
        total++;
        if (fe_n != 0 || ov_n != 0) begin bad++; $display("FAIL rmid_flags: got fe=%0d ov=%0d exp 0", fe_n, ov_n); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        rx4     = 1'b1;
        rx104   = 1'b1;
        busy    = 1'b0;
        busy104 = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_random();
        test_overrun();
        test_same_cycle();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_pixel_rx.md
UART_PIXEL_RX -- requirements
Module: uart_pixel_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, CLK cycles per UART bit (12 MHz / 115200); legal range 4..65535.
REQ-002 CLK  input  1  single system clock; all state on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 RX  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 i_busy  input  1  downstream pixel writer busy; byte not accepted while high.
REQ-006 o_data  output  8  received byte (pixel value), stable while o_valid high.
REQ-007 o_valid  output  1  o_data holds an unconsumed byte.
REQ-008 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 o_overrun  output  1  one-cycle pulse: byte completed while o_valid still high.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized signal rx_s only.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: on rx_s==0 go to START, clear bit counter and cycle counter.
REQ-013 START: at cycle count (CLKS_PER_BIT-1)/2 (integer division) sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output, no flag).
REQ-014 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit); shift into bit (bit index), LSB first; after bit 7 go to STOP.
REQ-015 STOP: sample rx_s after CLKS_PER_BIT cycles; 1 -> byte complete, go IDLE; 0 -> discard byte, pulse o_frame_err, go BREAK.
REQ-016 BREAK: remain until rx_s==1, then IDLE; no falling edge is treated as a start bit while in BREAK.
REQ-017 Byte complete with o_valid==0: next cycle o_data<=shift register, o_valid<=1.
REQ-018 Byte complete with o_valid==1: new byte dropped, o_data unchanged, o_overrun pulses one cycle.
REQ-019 Handshake: byte consumed in any cycle with o_valid==1 and i_busy==0; o_valid deasserts next cycle.
REQ-020 Consume and byte-complete in the same cycle: o_valid stays 1, o_data loads the new byte, no overrun.
REQ-021 o_data SHALL not change while o_valid==1 except per REQ-020.
REQ-022 Counters SHALL be wide enough for CLKS_PER_BIT-1 without wrap; cycle counter resets on every state change.
REQ-023 Latency: o_valid rises exactly 1 cycle after the stop-bit sample cycle.
REQ-024 Receiver SHALL keep decoding while o_valid is high (no back-pressure on RX).

Reset
REQ-025 RST high SHALL immediately force: FSM IDLE, counters 0, shift register 0, synchronizer flops 1, o_data 8'h00, o_valid 0, o_frame_err 0, o_overrun 0.
REQ-026 RST asserted mid-frame SHALL abandon the frame; after release, the remainder of that frame's bits are not reported as a byte unless a valid start bit is decoded.
REQ-027 First start bit is recognised no earlier than 2 cycles (synchronizer) after RST deasserts with RX low.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-028 Send 8'hA5, i_busy=0 -> o_valid high one cycle, o_data=8'hA5, no flags; repeat with CLKS_PER_BIT=104, byte 8'h3C -> o_data=8'h3C.
REQ-029 i_busy=1, send 8'h01 then 8'h02 -> o_data stays 8'h01, o_valid held, o_overrun pulses once at 2nd stop; release i_busy -> o_valid falls next cycle.
REQ-030 Send 8'hFF with stop bit forced 0, RX held low 20 bit-times, then 8'h55 -> one o_frame_err pulse, no o_valid for 8'hFF, 8'h55 received correctly.
REQ-031 RX low pulse of 1 cycle in IDLE -> no o_valid, no flags, FSM returns IDLE.
REQ-032 Assert RST after 4th data bit of 8'hC3, release, send 8'h7E -> all outputs 0 during reset, only 8'h7E reported.
REQ-033 i_busy falls in same cycle a new byte completes while o_valid=1 -> o_data updates to new byte, o_valid stays 1, no o_overrun.
